// File: rtl/dut_chk_pkg.sv
// Shared types and constants for the datapath response checker.
package dut_chk_pkg;

    localparam logic CMD_INC = 1'b0;
    localparam logic CMD_DEC = 1'b1;

    // Reference prediction width; the checker derives its own entry type from DATA_W.
    localparam int CHK_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FAIL
    } chk_state_t;

    typedef struct packed {
        logic                  valid;
        logic [CHK_DATA_W-1:0] exp;
        logic [CHK_DATA_W-1:0] addr;
    } pred_entry_t;

endpackage

// File: rtl/dut_pred_pipe.sv
// LATENCY-deep prediction delay line; shifts every cycle, valid bits clearable.
module dut_pred_pipe
    import dut_chk_pkg::*;
#(
    parameter int  LATENCY = 1,
    parameter type entry_t = pred_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clr_vld,
    input  entry_t push_entry,
    output entry_t out_entry,
    output logic   any_valid
);

    entry_t stage [LATENCY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
        end else begin
            stage[0] <= push_entry;
            for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
            // Payload may shift on, but nothing stays live after a clear.
            if (clr_vld) begin
                for (int i = 0; i < LATENCY; i++) stage[i].valid <= 1'b0;
            end
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < LATENCY; i++) any_valid = any_valid | stage[i].valid;
    end

    assign out_entry = stage[LATENCY-1];

endmodule

// File: rtl/dut_resp_checker.sv
// Predicts inc/dec datapath results and scores dout after a fixed latency.
// Optional macro CHECKER_LOG_EN adds first-mismatch capture ports and logging.
module dut_resp_checker
    import dut_chk_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int LATENCY     = 1,
    parameter int CNT_W       = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic              in_valid,
    input  logic              cmd,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              fail,
`ifdef CHECKER_LOG_EN
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_act,
    output logic [DATA_W-1:0] first_err_addr,
`endif
    output logic              busy
);

`ifdef CHECKER_LOG_EN
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] exp;
        logic [DATA_W-1:0] addr;
    } entry_t;
`else
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] exp;
    } entry_t;

    logic unused_addr;
    assign unused_addr = ^addr;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    chk_state_t        state, state_nxt;
    entry_t            push_e, last_e;
    logic [DATA_W-1:0] exp_val;
    logic              push, cmp, mis, any_vld;

    assign exp_val = (cmd == CMD_DEC) ? data - 1'b1 : data + 1'b1;
    assign push    = in_valid & enable & (state == RUN) & ~clear;
    assign cmp     = last_e.valid & (state != FAIL) & ~clear;
    assign mis     = cmp & (dout != last_e.exp);
    assign busy    = any_vld;

    always_comb begin
        push_e       = '0;
        push_e.valid = push;
        push_e.exp   = exp_val;
`ifdef CHECKER_LOG_EN
        push_e.addr  = addr;
`endif
    end

    dut_pred_pipe #(
        .LATENCY (LATENCY),
        .entry_t (entry_t)
    ) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .clr_vld    (clear),
        .push_entry (push_e),
        .out_entry  (last_e),
        .any_valid  (any_vld)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = any_vld ? DRAIN : IDLE;
            DRAIN:   if (enable) state_nxt = RUN;
                     else if (!any_vld) state_nxt = IDLE;
            FAIL:    state_nxt = FAIL;
            default: state_nxt = IDLE;
        endcase
        // A mismatch outranks the enable-driven transitions.
        if (STOP_ON_ERR != 0 && mis) state_nxt = FAIL;
        if (clear) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_cnt <= '0;
            err_cnt   <= '0;
            fail      <= 1'b0;
        end else if (clear) begin
            match_cnt <= '0;
            err_cnt   <= '0;
            fail      <= 1'b0;
        end else begin
            if (cmp && !mis && match_cnt != CNT_MAX) match_cnt <= match_cnt + 1'b1;
            if (mis) begin
                if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
                fail <= 1'b1;
            end
        end
    end

`ifdef CHECKER_LOG_EN
    // Only the first mismatch since reset/clear is captured; fail marks it taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_err_exp  <= '0;
            first_err_act  <= '0;
            first_err_addr <= '0;
        end else if (clear) begin
            first_err_exp  <= '0;
            first_err_act  <= '0;
            first_err_addr <= '0;
        end else if (mis) begin
            if (!fail) begin
                first_err_exp  <= last_e.exp;
                first_err_act  <= dout;
                first_err_addr <= last_e.addr;
            end
            $display("dut_resp_checker: mismatch addr=%0h exp=%0h act=%0h",
                     last_e.addr, last_e.exp, dout);
        end
    end
`endif

endmodule

// File: tb/tb_dut_resp_checker.sv
// Directed bench for dut_resp_checker: LATENCY=2, CNT_W=2, STOP_ON_ERR=1.
module tb_dut_resp_checker;
    import dut_chk_pkg::*;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0, clear = 1'b0, in_valid = 1'b0, cmd = 1'b0;
    logic [7:0] data = '0, addr = '0, dout = '0;
    logic [1:0] match_cnt, err_cnt;
    logic       fail, busy;
`ifdef CHECKER_LOG_EN
    logic [7:0] first_err_exp, first_err_act, first_err_addr;
`endif

    logic [7:0] dq [LAT];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dut_resp_checker #(
        .DATA_W      (8),
        .LATENCY     (LAT),
        .CNT_W       (2),
        .STOP_ON_ERR (1)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .clear          (clear),
        .in_valid       (in_valid),
        .cmd            (cmd),
        .data           (data),
        .addr           (addr),
        .dout           (dout),
        .match_cnt      (match_cnt),
        .err_cnt        (err_cnt),
        .fail           (fail),
`ifdef CHECKER_LOG_EN
        .first_err_exp  (first_err_exp),
        .first_err_act  (first_err_act),
        .first_err_addr (first_err_addr),
`endif
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // One cycle: drive a request and queue the dout the datapath shows LAT cycles later.
    task automatic step(input logic iv, input logic c, input logic [7:0] d,
                        input logic [7:0] a, input logic [7:0] want);
        in_valid = iv;
        cmd      = c;
        data     = d;
        addr     = a;
        dout     = dq[LAT-1];
        for (int i = LAT-1; i > 0; i--) dq[i] = dq[i-1];
        dq[0] = want;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < LAT; i++) dq[i] = '0;
        #12;
        chk("rst_match", 32'(match_cnt), 32'd0);
        chk("rst_err",   32'(err_cnt),   32'd0);
        chk("rst_fail",  32'(fail),      32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // basic increment
        enable = 1'b1;
        idle();
        chk("t1_run", 32'(u_dut.state), 32'(RUN));
        step(1'b1, CMD_INC, 8'h10, 8'h01, 8'h11);
        chk("t1_busy", 32'(busy), 32'd1);
        idle(); idle();
        chk("t1_match", 32'(match_cnt), 32'd1);
        chk("t1_err",   32'(err_cnt),   32'd0);
        chk("t1_fail",  32'(fail),      32'd0);
        chk("t1_idle_busy", 32'(busy),  32'd0);
        clear = 1'b1; idle(); clear = 1'b0;
        chk("clr_match", 32'(match_cnt), 32'd0);
        chk("clr_state", 32'(u_dut.state), 32'(IDLE));

        // wrap-around in both directions
        idle();
        step(1'b1, CMD_INC, 8'hFF, 8'h02, 8'h00);
        step(1'b1, CMD_DEC, 8'h00, 8'h03, 8'hFF);
        idle(); idle();
        chk("t2_match", 32'(match_cnt), 32'd2);
        chk("t2_err",   32'(err_cnt),   32'd0);

        // mismatch enters sticky FAIL
        step(1'b1, CMD_DEC, 8'h05, 8'hA3, 8'h05);
        idle(); idle();
        chk("t3_err",   32'(err_cnt),   32'd1);
        chk("t3_fail",  32'(fail),      32'd1);
        chk("t3_match", 32'(match_cnt), 32'd2);
        chk("t3_state", 32'(u_dut.state), 32'(FAIL));
`ifdef CHECKER_LOG_EN
        chk("t3_log_exp",  32'(first_err_exp),  32'h04);
        chk("t3_log_act",  32'(first_err_act),  32'h05);
        chk("t3_log_addr", 32'(first_err_addr), 32'hA3);
`endif
        step(1'b1, CMD_INC, 8'h20, 8'h04, 8'h21);
        chk("t3_nopush", 32'(busy), 32'd0);
        idle(); idle();
        chk("t3_frz_match", 32'(match_cnt), 32'd2);
        chk("t3_frz_err",   32'(err_cnt),   32'd1);
        clear = 1'b1; idle(); clear = 1'b0;
        chk("t3_clr_fail",  32'(fail),    32'd0);
        chk("t3_clr_err",   32'(err_cnt), 32'd0);
        chk("t3_clr_state", 32'(u_dut.state), 32'(IDLE));

        // enable drops with one request in flight; wrong douts expose any stray push
        idle();
        step(1'b1, CMD_INC, 8'h30, 8'h05, 8'h31);
        chk("t4_busy0", 32'(busy), 32'd1);
        enable = 1'b0;
        step(1'b1, CMD_INC, 8'h40, 8'h06, 8'h00);
        chk("t4_drain", 32'(u_dut.state), 32'(DRAIN));
        chk("t4_busy1", 32'(busy), 32'd1);
        step(1'b1, CMD_INC, 8'h50, 8'h07, 8'h00);
        chk("t4_match", 32'(match_cnt), 32'd1);
        chk("t4_busy2", 32'(busy), 32'd0);
        step(1'b1, CMD_INC, 8'h60, 8'h08, 8'h00);
        chk("t4_idle", 32'(u_dut.state), 32'(IDLE));
        idle(); idle();
        chk("t4_err",    32'(err_cnt),   32'd0);
        chk("t4_match2", 32'(match_cnt), 32'd1);

        // clear together with a request and a live compare
        enable = 1'b1;
        idle();
        step(1'b1, CMD_INC, 8'h60, 8'h09, 8'h61);
        idle();
        clear = 1'b1;
        step(1'b1, CMD_INC, 8'h70, 8'h0A, 8'h71);
        clear = 1'b0;
        chk("t5_match", 32'(match_cnt), 32'd0);
        chk("t5_err",   32'(err_cnt),   32'd0);
        chk("t5_fail",  32'(fail),      32'd0);
        chk("t5_busy",  32'(busy),      32'd0);
        chk("t5_state", 32'(u_dut.state), 32'(IDLE));
        idle(); idle();
        chk("t5_dropped", 32'(match_cnt), 32'd0);

        // back-to-back stream saturates a 2-bit counter
        step(1'b1, CMD_INC, 8'h01, 8'h10, 8'h02);
        step(1'b1, CMD_DEC, 8'h10, 8'h11, 8'h0F);
        step(1'b1, CMD_INC, 8'h7F, 8'h12, 8'h80);
        step(1'b1, CMD_DEC, 8'h80, 8'h13, 8'h7F);
        step(1'b1, CMD_INC, 8'hFE, 8'h14, 8'hFF);
        chk("t6_match3", 32'(match_cnt), 32'd3);
        idle(); idle();
        chk("t6_sat", 32'(match_cnt), 32'd3);
        chk("t6_err", 32'(err_cnt),   32'd0);

        // mismatch lands in the cycle enable falls
        step(1'b1, CMD_INC, 8'h80, 8'h0B, 8'h99);
        idle();
        enable = 1'b0;
        idle();
        chk("t7_err",   32'(err_cnt),   32'd1);
        chk("t7_fail",  32'(fail),      32'd1);
        chk("t7_state", 32'(u_dut.state), 32'(FAIL));
        chk("t7_match", 32'(match_cnt), 32'd3);
`ifdef CHECKER_LOG_EN
        chk("t7_log_exp",  32'(first_err_exp),  32'h81);
        chk("t7_log_act",  32'(first_err_act),  32'h99);
        chk("t7_log_addr", 32'(first_err_addr), 32'h0B);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
